// File: rtl/adc_scan.sv
// Multi-channel SPI ADC scanner: steps an analog mux across the enabled channels and
// reads each one over a read-only SPI link. Optional ADC_AVERAGE_EN adds per-channel averaging.
module adc_scan #(
  parameter int DATA_BITS     = 14,
  parameter int CAL_BITS      = 32,
  parameter int DIV_BITS      = 3,
  parameter int NUM_CH        = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int GAP_CYCLES    = 2,
`ifdef ADC_AVERAGE_EN
  parameter int AVG_LOG2      = 2,
`endif
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic [DIV_BITS-1:0]  clk_divider,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic                 calibrate,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic                 busy,
  output logic [CH_W-1:0]      mux_sel,
  output logic [DATA_BITS-1:0] data_o,
  output logic [CH_W-1:0]      data_ch,
  output logic                 data_valid,
  output logic                 sclk,
  input  logic                 miso,
  output logic                 cs
);

  localparam int BIT_MAX  = (CAL_BITS > DATA_BITS) ? CAL_BITS : DATA_BITS;
  localparam int BIT_W    = $clog2(BIT_MAX + 1);
  localparam int WAIT_MAX = (SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [BIT_W-1:0]  CAL_LAST    = BIT_W'(CAL_BITS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] GAP_LAST    = WAIT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, CAL, SETTLE, FRAME, GAP} state_t;

  state_t                state, state_nxt;
  logic [DIV_BITS-1:0]   div_lat, div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [NUM_CH-1:0]     mask_lat;
  logic [CH_W-1:0]       ch_q, ch_nxt;
  logic [DATA_BITS-1:0]  shift_q, result_w;
  logic                  ch_load, pub_q, sclk_q, cs_q;
  logic                  tick, fall, last_fall, more_conv, last_conv;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) lowest_ch = CH_W'(i);
  endfunction

  function automatic logic has_above(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c);
    has_above = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (m[i] && (i > int'(c))) has_above = 1'b1;
  endfunction

  function automatic logic [CH_W-1:0] next_above(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c);
    next_above = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && (i > int'(c))) next_above = CH_W'(i);
  endfunction

`ifdef ADC_AVERAGE_EN
  localparam int ACC_W = DATA_BITS + AVG_LOG2;
  localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc_q, acc_sum;
  logic [AVG_LOG2:0] avg_cnt;

  function automatic logic [DATA_BITS-1:0] avg_trunc(input logic [ACC_W-1:0] s);
    avg_trunc = DATA_BITS'(s >> AVG_LOG2);
  endfunction

  assign acc_sum   = acc_q + ACC_W'(shift_q);
  assign result_w  = avg_trunc(acc_sum);
  assign more_conv = (avg_cnt != AVG_LAST);
  assign last_conv = ~more_conv;

  // Accumulator is cleared whenever a channel is abandoned or finished
  always_ff @(posedge clkin) begin
    if (stop || state == IDLE)
      acc_q <= '0;
    else if (state == GAP && pub_q)
      acc_q <= last_conv ? '0 : acc_sum;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst)
      avg_cnt <= '0;
    else if (state == IDLE || (state_nxt == SETTLE && state != SETTLE))
      avg_cnt <= '0;
    else if (state == GAP && state_nxt == FRAME)
      avg_cnt <= avg_cnt + 1'b1;
  end
`else
  assign result_w  = shift_q;
  assign more_conv = 1'b0;
  assign last_conv = 1'b1;
`endif

  assign busy    = (state != IDLE);
  assign mux_sel = ch_q;
  assign sclk    = sclk_q;
  assign cs      = cs_q;

  always_comb begin
    state_nxt = state;
    ch_nxt    = ch_q;
    ch_load   = 1'b0;
    tick      = (div_cnt == div_lat);
    fall      = tick && sclk_q;
    last_fall = 1'b0;
    if (state == CAL)
      last_fall = fall && (bit_cnt == CAL_LAST);
    else if (state == FRAME)
      last_fall = fall && (bit_cnt == DATA_LAST);
    case (state)
      IDLE: begin
        if (start && ch_mask != '0) begin
          state_nxt = calibrate ? CAL : SETTLE;
          ch_nxt    = lowest_ch(ch_mask);
          ch_load   = 1'b1;
        end
      end
      CAL:    if (last_fall) state_nxt = SETTLE;
      SETTLE: if (wait_cnt == SETTLE_LAST) state_nxt = FRAME;
      FRAME:  if (last_fall) state_nxt = GAP;
      GAP: begin
        if (wait_cnt == GAP_LAST) begin
          if (more_conv) begin
            state_nxt = FRAME;
          end else if (has_above(mask_lat, ch_q)) begin
            state_nxt = SETTLE;
            ch_nxt    = next_above(mask_lat, ch_q);
            ch_load   = 1'b1;
          end else if (continuous) begin
            state_nxt = SETTLE;
            ch_nxt    = lowest_ch(mask_lat);
            ch_load   = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
      ch_nxt    = ch_q;
      ch_load   = 1'b0;
    end
  end

  always_ff @(posedge clkin) begin
    if (state == FRAME && fall)
      shift_q <= {shift_q[DATA_BITS-2:0], miso};
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ch_q       <= '0;
      mask_lat   <= '0;
      div_lat    <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      pub_q      <= 1'b0;
      data_o     <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_valid <= 1'b0;
      pub_q      <= (state == FRAME) && (state_nxt == GAP);
      if (ch_load) ch_q <= ch_nxt;
      if (state == IDLE && state_nxt != IDLE) mask_lat <= ch_mask;

      if ((state_nxt == SETTLE || state_nxt == GAP) && state_nxt == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      // SPI clock engine: shared by calibration and data frames
      if (state_nxt == FRAME || state_nxt == CAL) begin
        if (state_nxt != state) begin
          div_lat <= clk_divider;
          div_cnt <= '0;
          bit_cnt <= '0;
          sclk_q  <= 1'b0;
          cs_q    <= 1'b0;
        end else if (tick) begin
          div_cnt <= '0;
          sclk_q  <= ~sclk_q;
          if (fall) bit_cnt <= bit_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else begin
        sclk_q <= 1'b0;
        cs_q   <= 1'b1;
      end

      if (state == GAP && pub_q && !stop && last_conv) begin
        data_o     <= result_w;
        data_ch    <= ch_q;
        data_valid <= 1'b1;
      end
    end
  end

endmodule
